// File: rtl/cbuf_fmt_pkg.sv
// CBUF acquisition word format shared between the DDR3 writer and the readout parser:
// tag codes, header marker and header field bit positions.
package cbuf_fmt_pkg;

  localparam int TAG_W     = 4;
  localparam int PAY_W     = 128;
  localparam int WORD_W    = TAG_W + PAY_W;
  localparam int LANE_W    = 16;
  localparam int NUM_LANES = PAY_W / LANE_W;

  localparam logic [TAG_W-1:0] FILL_HDR = 4'd1;
  localparam logic [TAG_W-1:0] WFM_HDR  = 4'd2;
  localparam logic [TAG_W-1:0] DATA     = 4'd3;
  localparam logic [TAG_W-1:0] CKSUM    = 4'd4;

  localparam logic [1:0] HDR_MARK     = 2'b01;
  localparam int         HDR_MARK_LSB = 126;

  // Fill header fields
  localparam int FILL_NUM_LSB   = 0;
  localparam int FILL_NUM_W     = 24;
  localparam int FILL_TYPE_LSB  = 24;
  localparam int FILL_TYPE_W    = 2;
  localparam int NUM_BURSTS_LSB = 27;
  localparam int NUM_BURSTS_W   = 14;
  localparam int BURST_ADR_LSB  = 53;
  localparam int BURST_ADR_W    = 23;
  localparam int PRE_TRIG_LSB   = 88;
  localparam int PRE_TRIG_W     = 16;
  localparam int CHAN_TAG_LSB   = 110;
  localparam int CHAN_TAG_W     = 12;

  // Waveform header fields
  localparam int WFM_NB_LSB   = 0;
  localparam int XADC_LSB     = 110;
  localparam int XADC_W       = 4;
  localparam int WFM_FLAG_BIT = 114;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WHDR  = 2'd1,
    S_DATA  = 2'd2,
    S_CKSUM = 2'd3
  } state_e;

  function automatic logic hdr_marked(input logic [PAY_W-1:0] pay);
    return pay[HDR_MARK_LSB +: 2] == HDR_MARK;
  endfunction

endpackage

// File: rtl/cbuf_lane_unpack.sv
// Splits a 128-bit data payload into eight ADC samples and flags lanes whose
// upper bits are not a sign extension of the sample.
module cbuf_lane_unpack
  import cbuf_fmt_pkg::*;
#(
  parameter int SAMPLE_W = 12
) (
  input  logic [PAY_W-1:0]              payload_i,
  output logic [NUM_LANES*SAMPLE_W-1:0] smp_o,
  output logic [NUM_LANES-1:0]          sext_err_o
);

  localparam int EXT_W = LANE_W - SAMPLE_W;

  always_comb begin
    smp_o      = '0;
    sext_err_o = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      smp_o[i*SAMPLE_W +: SAMPLE_W] = payload_i[i*LANE_W +: SAMPLE_W];
      sext_err_o[i] = payload_i[i*LANE_W + SAMPLE_W +: EXT_W]
                      != {EXT_W{payload_i[i*LANE_W + SAMPLE_W - 1]}};
    end
  end

endmodule

// File: rtl/cbuf_readout_parser.sv
// Receive-side parser for the CBUF word stream: header decode, sample unpack,
// XOR checksum recomputation and error flagging.
module cbuf_readout_parser
  import cbuf_fmt_pkg::*;
#(
  parameter int SAMPLE_W = 12,
  parameter int ERRCNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WORD_W-1:0]             in_dat,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [FILL_NUM_W-1:0]         fill_num,
  output logic [FILL_TYPE_W-1:0]        fill_type,
  output logic [NUM_BURSTS_W-1:0]       num_bursts,
  output logic [BURST_ADR_W-1:0]        burst_adr,
  output logic [PRE_TRIG_W-1:0]         pre_trig,
  output logic [CHAN_TAG_W-1:0]         channel_tag,
  output logic [XADC_W-1:0]             xadc_alarms,
  output logic                          hdr_valid,
  output logic [NUM_LANES*SAMPLE_W-1:0] smp_dat,
  output logic                          smp_valid,
  input  logic                          smp_ready,
  output logic                          fill_done,
  output logic                          cksum_ok,
  output logic                          err_tag,
  output logic                          err_sext,
  output logic [ERRCNT_W-1:0]           err_count
);

  localparam int SMP_W = NUM_LANES * SAMPLE_W;

  state_e                  state_q, state_d;
  logic [PAY_W-1:0]        chk_q, chk_d;
  logic [NUM_BURSTS_W-1:0] cnt_q, cnt_d;
  logic [FILL_NUM_W-1:0]   fill_num_q, fill_num_d;
  logic [FILL_TYPE_W-1:0]  fill_type_q, fill_type_d;
  logic [NUM_BURSTS_W-1:0] num_bursts_q, num_bursts_d;
  logic [BURST_ADR_W-1:0]  burst_adr_q, burst_adr_d;
  logic [PRE_TRIG_W-1:0]   pre_trig_q, pre_trig_d;
  logic [CHAN_TAG_W-1:0]   chan_tag_q, chan_tag_d;
  logic [XADC_W-1:0]       xadc_q, xadc_d;
  logic [SMP_W-1:0]        smp_dat_q, smp_dat_d;
  logic                    smp_valid_q, smp_valid_d;
  logic                    hdr_valid_q, hdr_valid_d;
  logic                    fill_done_q, fill_done_d;
  logic                    cksum_ok_q, cksum_ok_d;
  logic                    err_tag_q, err_tag_d;
  logic                    err_sext_q, err_sext_d;
  logic [ERRCNT_W-1:0]     err_cnt_q, err_cnt_d;

  logic [TAG_W-1:0]        tag;
  logic [PAY_W-1:0]        pay;
  logic                    accept;
  logic                    is_fill;
  logic                    take_fill;
  logic [SMP_W-1:0]        unp_smp;
  logic [NUM_LANES-1:0]    unp_sext;
  logic [ERRCNT_W:0]       err_sum;

  assign tag     = in_dat[WORD_W-1 -: TAG_W];
  assign pay     = in_dat[PAY_W-1:0];
  // The output register only throttles input while data words are being forwarded
  assign in_ready = !rst && ((state_q != S_DATA) || !smp_valid_q || smp_ready);
  assign accept  = in_valid && in_ready;
  assign is_fill = (tag == FILL_HDR) && hdr_marked(pay);

  cbuf_lane_unpack #(
    .SAMPLE_W (SAMPLE_W)
  ) u_unpack (
    .payload_i  (pay),
    .smp_o      (unp_smp),
    .sext_err_o (unp_sext)
  );

  always_comb begin
    state_d      = state_q;
    chk_d        = chk_q;
    cnt_d        = cnt_q;
    fill_num_d   = fill_num_q;
    fill_type_d  = fill_type_q;
    num_bursts_d = num_bursts_q;
    burst_adr_d  = burst_adr_q;
    pre_trig_d   = pre_trig_q;
    chan_tag_d   = chan_tag_q;
    xadc_d       = xadc_q;
    smp_dat_d    = smp_dat_q;
    smp_valid_d  = smp_valid_q && !smp_ready;
    hdr_valid_d  = 1'b0;
    fill_done_d  = 1'b0;
    cksum_ok_d   = 1'b0;
    err_tag_d    = 1'b0;
    err_sext_d   = 1'b0;
    take_fill    = 1'b0;

    if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (is_fill) take_fill = 1'b1;
          else         err_tag_d = 1'b1;
        end
        S_WHDR: begin
          if (tag == WFM_HDR && hdr_marked(pay)) begin
            chk_d       = chk_q ^ pay;
            xadc_d      = pay[XADC_LSB +: XADC_W];
            hdr_valid_d = 1'b1;
            err_tag_d   = (pay[WFM_NB_LSB +: NUM_BURSTS_W] != num_bursts_q) || !pay[WFM_FLAG_BIT];
            cnt_d       = num_bursts_q;
            state_d     = (num_bursts_q == '0) ? S_CKSUM : S_DATA;
          end else begin
            err_tag_d = 1'b1;
            take_fill = is_fill;
            state_d   = S_IDLE;
          end
        end
        S_DATA: begin
          if (tag == DATA) begin
            chk_d       = chk_q ^ pay;
            smp_dat_d   = unp_smp;
            smp_valid_d = 1'b1;
            err_sext_d  = |unp_sext;
            cnt_d       = cnt_q - NUM_BURSTS_W'(1);
            if (cnt_q == NUM_BURSTS_W'(1)) state_d = S_CKSUM;
          end else begin
            err_tag_d = 1'b1;
            take_fill = is_fill;
            state_d   = S_IDLE;
          end
        end
        S_CKSUM: begin
          if (tag == CKSUM) begin
            fill_done_d = 1'b1;
            cksum_ok_d  = (pay == chk_q);
          end else begin
            err_tag_d = 1'b1;
            take_fill = is_fill;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A fill header seen while abandoning a fill starts the next fill directly
    if (take_fill) begin
      fill_num_d   = pay[FILL_NUM_LSB   +: FILL_NUM_W];
      fill_type_d  = pay[FILL_TYPE_LSB  +: FILL_TYPE_W];
      num_bursts_d = pay[NUM_BURSTS_LSB +: NUM_BURSTS_W];
      burst_adr_d  = pay[BURST_ADR_LSB  +: BURST_ADR_W];
      pre_trig_d   = pay[PRE_TRIG_LSB   +: PRE_TRIG_W];
      chan_tag_d   = pay[CHAN_TAG_LSB   +: CHAN_TAG_W];
      chk_d        = pay;
      state_d      = S_WHDR;
    end

    err_sum   = {1'b0, err_cnt_q} + (ERRCNT_W+1)'(err_tag_d) + (ERRCNT_W+1)'(err_sext_d);
    err_cnt_d = err_sum[ERRCNT_W] ? {ERRCNT_W{1'b1}} : err_sum[ERRCNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      chk_q        <= '0;
      cnt_q        <= '0;
      fill_num_q   <= '0;
      fill_type_q  <= '0;
      num_bursts_q <= '0;
      burst_adr_q  <= '0;
      pre_trig_q   <= '0;
      chan_tag_q   <= '0;
      xadc_q       <= '0;
      smp_dat_q    <= '0;
      smp_valid_q  <= 1'b0;
      hdr_valid_q  <= 1'b0;
      fill_done_q  <= 1'b0;
      cksum_ok_q   <= 1'b0;
      err_tag_q    <= 1'b0;
      err_sext_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      chk_q        <= chk_d;
      cnt_q        <= cnt_d;
      fill_num_q   <= fill_num_d;
      fill_type_q  <= fill_type_d;
      num_bursts_q <= num_bursts_d;
      burst_adr_q  <= burst_adr_d;
      pre_trig_q   <= pre_trig_d;
      chan_tag_q   <= chan_tag_d;
      xadc_q       <= xadc_d;
      smp_dat_q    <= smp_dat_d;
      smp_valid_q  <= smp_valid_d;
      hdr_valid_q  <= hdr_valid_d;
      fill_done_q  <= fill_done_d;
      cksum_ok_q   <= cksum_ok_d;
      err_tag_q    <= err_tag_d;
      err_sext_q   <= err_sext_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign fill_num    = fill_num_q;
  assign fill_type   = fill_type_q;
  assign num_bursts  = num_bursts_q;
  assign burst_adr   = burst_adr_q;
  assign pre_trig    = pre_trig_q;
  assign channel_tag = chan_tag_q;
  assign xadc_alarms = xadc_q;
  assign hdr_valid   = hdr_valid_q;
  assign smp_dat     = smp_dat_q;
  assign smp_valid   = smp_valid_q;
  assign fill_done   = fill_done_q;
  assign cksum_ok    = cksum_ok_q;
  assign err_tag     = err_tag_q;
  assign err_sext    = err_sext_q;
  assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_cbuf_readout_parser.sv
// Directed bench for cbuf_readout_parser: builds word streams, counts output
// pulses on the falling edge and checks them against hand-derived expectations.
module tb_cbuf_readout_parser;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [131:0] in_dat = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [23:0]  fill_num;
  logic [1:0]   fill_type;
  logic [13:0]  num_bursts;
  logic [22:0]  burst_adr;
  logic [15:0]  pre_trig;
  logic [11:0]  channel_tag;
  logic [3:0]   xadc_alarms;
  logic         hdr_valid;
  logic [95:0]  smp_dat;
  logic         smp_valid;
  logic         smp_ready = 1'b1;
  logic         fill_done;
  logic         cksum_ok;
  logic         err_tag;
  logic         err_sext;
  logic [15:0]  err_count;

  int errors = 0;
  int checks = 0;

  cbuf_readout_parser dut (
    .clk         (clk),
    .rst         (rst),
    .in_dat      (in_dat),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .fill_num    (fill_num),
    .fill_type   (fill_type),
    .num_bursts  (num_bursts),
    .burst_adr   (burst_adr),
    .pre_trig    (pre_trig),
    .channel_tag (channel_tag),
    .xadc_alarms (xadc_alarms),
    .hdr_valid   (hdr_valid),
    .smp_dat     (smp_dat),
    .smp_valid   (smp_valid),
    .smp_ready   (smp_ready),
    .fill_done   (fill_done),
    .cksum_ok    (cksum_ok),
    .err_tag     (err_tag),
    .err_sext    (err_sext),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // Falling-edge monitor: pulse counts and captured sample beats
  int          n_hdr = 0, n_beat = 0, n_done = 0, n_ok = 0, n_etag = 0, n_esext = 0;
  logic [95:0] cap [0:63];

  always @(negedge clk) begin
    if (hdr_valid) n_hdr++;
    if (fill_done) n_done++;
    if (fill_done && cksum_ok) n_ok++;
    if (err_tag) n_etag++;
    if (err_sext) n_esext++;
    if (smp_valid && smp_ready) begin
      cap[n_beat % 64] = smp_dat;
      n_beat++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [131:0] mk_fill(input logic [23:0] fn, input logic [1:0] ft,
                                           input logic [13:0] nb, input logic [22:0] adr,
                                           input logic [15:0] pt, input logic [11:0] ct);
    logic [127:0] p;
    p = '0;
    p[127:126] = 2'b01;
    p[23:0]    = fn;
    p[25:24]   = ft;
    p[40:27]   = nb;
    p[75:53]   = adr;
    p[103:88]  = pt;
    p[121:110] = ct;
    return {4'd1, p};
  endfunction

  function automatic logic [131:0] mk_wfm(input logic [13:0] nb, input logic [3:0] al);
    logic [127:0] p;
    p = '0;
    p[127:126] = 2'b01;
    p[114]     = 1'b1;
    p[113:110] = al;
    p[13:0]    = nb;
    return {4'd2, p};
  endfunction

  function automatic logic [131:0] mk_data(input logic [95:0] s);
    logic [127:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) p[i*16 +: 16] = {{4{s[i*12+11]}}, s[i*12 +: 12]};
    return {4'd3, p};
  endfunction

  task automatic send(input logic [131:0] w);
    int t;
    t = 0;
    in_dat   = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout", 128'(t), 128'(0));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  logic [131:0] w_f, w_w, d0, d1, ck, d5, fa, fb;
  logic [95:0]  s0, s1, s5;
  logic [95:0]  s4 [0:3];
  logic [127:0] acc;
  int b_hdr, b_beat, b_done, b_ok, b_etag, b_esext;

  task automatic snap();
    b_hdr = n_hdr; b_beat = n_beat; b_done = n_done;
    b_ok = n_ok; b_etag = n_etag; b_esext = n_esext;
  endtask

  initial begin
    s0 = 96'h123456789ABCDEF8007FF001;
    s1 = 96'hFFF000A5A5A5321CDE0F0F0F;
    w_f = mk_fill(24'hABCDE1, 2'd2, 14'd2, 23'h5A5A5A, 16'hBEEF, 12'h7C3);
    w_w = mk_wfm(14'd2, 4'h9);
    d0  = mk_data(s0);
    d1  = mk_data(s1);
    ck  = {4'd4, w_f[127:0] ^ w_w[127:0] ^ d0[127:0] ^ d1[127:0]};

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_smp_valid", 128'(smp_valid), 128'(0));
    chk("rst_err_count", 128'(err_count), 128'(0));
    chk("rst_fill_num", 128'(fill_num), 128'(0));
    chk("rst_fill_done", 128'(fill_done), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;

    // 1: two data words, correct checksum
    snap();
    send(w_f); send(w_w); send(d0); send(d1); send(ck);
    repeat (3) @(negedge clk);
    chk("t1_hdr_valid", 128'(n_hdr - b_hdr), 128'(1));
    chk("t1_beats", 128'(n_beat - b_beat), 128'(2));
    chk("t1_smp0", 128'(cap[b_beat % 64]), 128'(s0));
    chk("t1_smp1", 128'(cap[(b_beat + 1) % 64]), 128'(s1));
    chk("t1_fill_done", 128'(n_done - b_done), 128'(1));
    chk("t1_cksum_ok", 128'(n_ok - b_ok), 128'(1));
    chk("t1_fill_num", 128'(fill_num), 128'(24'hABCDE1));
    chk("t1_fill_type", 128'(fill_type), 128'(2'd2));
    chk("t1_num_bursts", 128'(num_bursts), 128'(14'd2));
    chk("t1_burst_adr", 128'(burst_adr), 128'(23'h5A5A5A));
    chk("t1_pre_trig", 128'(pre_trig), 128'(16'hBEEF));
    chk("t1_channel_tag", 128'(channel_tag), 128'(12'h7C3));
    chk("t1_xadc", 128'(xadc_alarms), 128'(4'h9));
    chk("t1_err_count", 128'(err_count), 128'(0));
    @(posedge clk);
    #1;

    // 2: same stream, checksum bit0 flipped
    snap();
    send(w_f); send(w_w); send(d0); send(d1); send(ck ^ 132'd1);
    repeat (3) @(negedge clk);
    chk("t2_fill_done", 128'(n_done - b_done), 128'(1));
    chk("t2_cksum_ok", 128'(n_ok - b_ok), 128'(0));
    chk("t2_err_count", 128'(err_count), 128'(0));
    @(posedge clk);
    #1;

    // 3: zero bursts
    snap();
    fa = mk_fill(24'h000010, 2'd0, 14'd0, 23'h000001, 16'h0000, 12'h001);
    fb = mk_wfm(14'd0, 4'h0);
    send(fa); send(fb); send({4'd4, fa[127:0] ^ fb[127:0]});
    repeat (3) @(negedge clk);
    chk("t3_beats", 128'(n_beat - b_beat), 128'(0));
    chk("t3_hdr_valid", 128'(n_hdr - b_hdr), 128'(1));
    chk("t3_fill_done", 128'(n_done - b_done), 128'(1));
    chk("t3_cksum_ok", 128'(n_ok - b_ok), 128'(1));
    @(posedge clk);
    #1;

    // 4: downstream stall across four back-to-back data words
    s4[0] = 96'h001002003004005006007008;
    s4[1] = 96'h800801802803804805806807;
    s4[2] = 96'hFFFFFEFFDFFCFFBFFAFF9FF8;
    s4[3] = 96'h7FF7FE7FD7FC7FB7FA7F97F8;
    fa = mk_fill(24'h000444, 2'd1, 14'd4, 23'h000100, 16'h0040, 12'h044);
    fb = mk_wfm(14'd4, 4'h4);
    acc = fa[127:0] ^ fb[127:0];
    for (int k = 0; k < 4; k++) begin
      d5 = mk_data(s4[k]);
      acc = acc ^ d5[127:0];
    end
    snap();
    send(fa); send(fb);
    smp_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) send(mk_data(s4[k]));
        send({4'd4, acc});
      end
      begin
        @(negedge clk);
        @(negedge clk);
        chk("t4_stall_in_ready", 128'(in_ready), 128'(0));
        chk("t4_stall_smp_valid", 128'(smp_valid), 128'(1));
        chk("t4_stall_smp_dat", 128'(smp_dat), 128'(s4[0]));
        repeat (4) @(posedge clk);
        #1 smp_ready = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    chk("t4_beats", 128'(n_beat - b_beat), 128'(4));
    for (int k = 0; k < 4; k++)
      chk($sformatf("t4_smp%0d", k), 128'(cap[(b_beat + k) % 64]), 128'(s4[k]));
    chk("t4_fill_done", 128'(n_done - b_done), 128'(1));
    chk("t4_cksum_ok", 128'(n_ok - b_ok), 128'(1));
    chk("t4_err_count", 128'(err_count), 128'(0));
    @(posedge clk);
    #1;

    // 5: lane3 = 16'h0800 is not a valid sign extension
    s5 = 96'h111222333444800555666777;
    d5 = mk_data(s5);
    d5[63:60] = 4'h0;
    fa = mk_fill(24'h000555, 2'd3, 14'd1, 23'h000200, 16'h0005, 12'h055);
    fb = mk_wfm(14'd1, 4'h5);
    snap();
    send(fa); send(fb); send(d5); send({4'd4, fa[127:0] ^ fb[127:0] ^ d5[127:0]});
    repeat (3) @(negedge clk);
    chk("t5_err_sext", 128'(n_esext - b_esext), 128'(1));
    chk("t5_err_tag", 128'(n_etag - b_etag), 128'(0));
    chk("t5_err_count", 128'(err_count), 128'(1));
    chk("t5_beats", 128'(n_beat - b_beat), 128'(1));
    chk("t5_smp", 128'(cap[b_beat % 64]), 128'(s5));
    chk("t5_cksum_ok", 128'(n_ok - b_ok), 128'(1));
    @(posedge clk);
    #1;

    // Stray data word while idle
    snap();
    send(d0);
    repeat (2) @(negedge clk);
    chk("idle_err_tag", 128'(n_etag - b_etag), 128'(1));
    chk("idle_err_count", 128'(err_count), 128'(2));
    chk("idle_beats", 128'(n_beat - b_beat), 128'(0));
    @(posedge clk);
    #1;

    // 6: fill header in WHDR restarts the fill; reset mid-DATA
    fa = mk_fill(24'h111111, 2'd1, 14'd3, 23'h000300, 16'h0011, 12'h111);
    fb = mk_fill(24'h222222, 2'd3, 14'd2, 23'h7FFFFF, 16'h0102, 12'hFFF);
    snap();
    send(fa); send(fb);
    repeat (2) @(negedge clk);
    chk("t6_err_tag", 128'(n_etag - b_etag), 128'(1));
    chk("t6_fill_num", 128'(fill_num), 128'(24'h222222));
    chk("t6_num_bursts", 128'(num_bursts), 128'(14'd2));
    chk("t6_err_count", 128'(err_count), 128'(3));
    @(posedge clk);
    #1;
    send(mk_wfm(14'd2, 4'h3));
    smp_ready = 1'b0;
    send(d0);
    @(negedge clk);
    chk("t6_hdr_ok_no_tag_err", 128'(n_etag - b_etag), 128'(1));
    chk("t6_xadc", 128'(xadc_alarms), 128'(4'h3));
    chk("t6_smp_pending", 128'(smp_valid), 128'(1));
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_smp_valid", 128'(smp_valid), 128'(0));
    chk("t6_rst_fill_num", 128'(fill_num), 128'(0));
    chk("t6_rst_err_count", 128'(err_count), 128'(0));
    chk("t6_rst_xadc", 128'(xadc_alarms), 128'(0));
    @(posedge clk);
    #1 begin rst = 1'b0; smp_ready = 1'b1; end
    @(negedge clk);
    chk("t6_post_rst_in_ready", 128'(in_ready), 128'(1));
    chk("t6_no_fill_done", 128'(n_done - b_done), 128'(0));
    @(posedge clk);
    #1;
    snap();
    send(w_f); send(w_w); send(d0); send(d1); send(ck);
    repeat (3) @(negedge clk);
    chk("t6_re_hdr", 128'(n_hdr - b_hdr), 128'(1));
    chk("t6_re_beats", 128'(n_beat - b_beat), 128'(2));
    chk("t6_re_smp1", 128'(cap[(b_beat + 1) % 64]), 128'(s1));
    chk("t6_re_cksum_ok", 128'(n_ok - b_ok), 128'(1));
    chk("t6_re_err_count", 128'(err_count), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
